// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin arbiter that shares one multi-cycle unsigned
// divider among NREQ requesters. It accepts one request at a time, runs the
// divider's start/done handshake, and answers the granted requester with a
// one-cycle response strobe.
// Optional feature macro: DIV_ARB_DBZ_BYPASS_EN. When defined, a zero divisor
// is answered directly, without using the divider.

// Protocol checker for the divider status lines.
module div_share_arbiter_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_div_done,
  input logic i_div_dbz,
  input logic i_div_valid
);
  // A completed non-zero divide must report a valid result.
  a_done_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_div_done && !i_div_dbz) |-> i_div_valid);
endmodule

module div_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [IDXW-1:0]       o_rsp_idx,
  output logic [WIDTH-1:0]      o_rsp_quo,
  output logic [WIDTH-1:0]      o_rsp_rem,
  output logic                  o_rsp_dbz,
  output logic                  o_arb_busy,
  output logic                  o_div_start,
  output logic [WIDTH-1:0]      o_div_a,
  output logic [WIDTH-1:0]      o_div_b,
  input  logic                  i_div_busy,
  input  logic                  i_div_done,
  input  logic                  i_div_valid,
  input  logic                  i_div_dbz,
  input  logic [WIDTH-1:0]      i_div_val,
  input  logic [WIDTH-1:0]      i_div_rem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_div_a;
  logic [WIDTH-1:0]  r_div_b;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [IDXW-1:0]   r_rsp_idx;
  logic [WIDTH-1:0]  r_rsp_quo;
  logic [WIDTH-1:0]  r_rsp_rem;
  logic              r_rsp_dbz;

  logic              w_found;
  logic              w_hit;
  logic [IDXW:0]     w_sum;
  logic [IDXW:0]     w_cand;
  logic [IDXW-1:0]   w_grant_idx;
  logic [NREQ-1:0]   w_grant_oh;
  logic [WIDTH-1:0]  w_grant_a;
  logic [WIDTH-1:0]  w_grant_b;
  logic [IDXW-1:0]   w_ptr_nxt;
  logic              w_accept;
  logic              w_bypass;
  logic              w_div_done_wait;

  // Round-robin search starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found     = 1'b0;
    w_hit       = 1'b0;
    w_sum       = {(IDXW+1){1'b0}};
    w_cand      = {(IDXW+1){1'b0}};
    w_grant_idx = {IDXW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_sum       = {1'b0, r_ptr} + (IDXW+1)'(k);
      w_cand      = (w_sum >= (IDXW+1)'(NREQ)) ? (w_sum - (IDXW+1)'(NREQ)) : w_sum;
      w_hit       = !w_found && i_req_valid[w_cand[IDXW-1:0]];
      w_grant_idx = w_hit ? w_cand[IDXW-1:0] : w_grant_idx;
      w_found     = w_found | w_hit;
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    w_grant_a = {WIDTH{1'b0}};
    w_grant_b = {WIDTH{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      w_grant_a = (IDXW'(j) == w_grant_idx) ? i_req_a[j*WIDTH +: WIDTH] : w_grant_a;
      w_grant_b = (IDXW'(j) == w_grant_idx) ? i_req_b[j*WIDTH +: WIDTH] : w_grant_b;
    end
  end

  assign w_grant_oh = w_found ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : {NREQ{1'b0}};
  assign w_ptr_nxt  = (w_grant_idx == IDXW'(NREQ-1)) ? {IDXW{1'b0}}
                                                       : (w_grant_idx + {{(IDXW-1){1'b0}}, 1'b1});
  assign w_accept   = |(i_req_valid & o_req_ready);
  // Divider completion only counts while a divide is outstanding.
  assign w_div_done_wait = (r_state == S_WAIT) && i_div_done;

`ifdef DIV_ARB_DBZ_BYPASS_EN
  assign w_bypass = (w_grant_b == {WIDTH{1'b0}});
`else
  assign w_bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: grant, issue once the divider is free, wait for done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_bypass) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_div_busy) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_div_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: grant only in IDLE, start pulse while issuing.
  always_comb begin
    o_req_ready = {NREQ{1'b0}};
    o_div_start = 1'b0;
    o_arb_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = i_rst ? {NREQ{1'b0}} : w_grant_oh;
      end
      S_ISSUE: begin
        o_arb_busy  = 1'b1;
        o_div_start = !i_div_busy;
      end
      S_WAIT: begin
        o_arb_busy  = 1'b1;
      end
      default: begin
        o_arb_busy  = 1'b0;
      end
    endcase
  end

  // Request latch, pointer rotation and response registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= {IDXW{1'b0}};
      r_idx       <= {IDXW{1'b0}};
      r_div_a     <= {WIDTH{1'b0}};
      r_div_b     <= {WIDTH{1'b0}};
      r_rsp_valid <= {NREQ{1'b0}};
      r_rsp_idx   <= {IDXW{1'b0}};
      r_rsp_quo   <= {WIDTH{1'b0}};
      r_rsp_rem   <= {WIDTH{1'b0}};
      r_rsp_dbz   <= 1'b0;
    end else begin
      r_rsp_valid <= {NREQ{1'b0}};
      if (w_accept) begin
        r_idx   <= w_grant_idx;
        r_div_a <= w_grant_a;
        r_div_b <= w_grant_b;
        r_ptr   <= w_ptr_nxt;
        if (w_bypass) begin
          // Zero divisor answered locally: all-ones quotient, dividend as remainder.
          r_rsp_valid <= w_grant_oh;
          r_rsp_idx   <= w_grant_idx;
          r_rsp_quo   <= {WIDTH{1'b1}};
          r_rsp_rem   <= w_grant_a;
          r_rsp_dbz   <= 1'b1;
        end else begin
          r_rsp_dbz   <= r_rsp_dbz;
        end
      end else if (w_div_done_wait) begin
        // On divide-by-zero the divider's data outputs are stale; return zeros.
        r_rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
        r_rsp_idx   <= r_idx;
        r_rsp_quo   <= i_div_dbz ? {WIDTH{1'b0}} : i_div_val;
        r_rsp_rem   <= i_div_dbz ? {WIDTH{1'b0}} : i_div_rem;
        r_rsp_dbz   <= i_div_dbz;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_idx   = r_rsp_idx;
  assign o_rsp_quo   = r_rsp_quo;
  assign o_rsp_rem   = r_rsp_rem;
  assign o_rsp_dbz   = r_rsp_dbz;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;

  div_share_arbiter_chk u_chk (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_div_done  (i_div_done),
    .i_div_dbz   (i_div_dbz),
    .i_div_valid (i_div_valid)
  );

endmodule

// File: tb/tb_div_share_arbiter.sv
// Testbench for div_share_arbiter with a behavioural divider model and a
// response scoreboard. Honours DIV_ARB_DBZ_BYPASS_EN for the zero-divisor case.
module tb_div_share_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDXW  = 2;

  typedef struct {
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDXW-1:0]       rsp_idx;
  logic [WIDTH-1:0]      rsp_quo;
  logic [WIDTH-1:0]      rsp_rem;
  logic                  rsp_dbz;
  logic                  arb_busy;
  logic                  div_start;
  logic [WIDTH-1:0]      div_a;
  logic [WIDTH-1:0]      div_b;

  // divider model state
  logic             m_busy, m_done, m_valid, m_dbz;
  logic [WIDTH-1:0] m_val, m_rem, m_a, m_b;
  int               m_cnt;
  logic             tb_busy, tb_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t sb_q[$];
  logic [WIDTH-1:0] st_a, st_b;

  always #5 clk = ~clk;

  div_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDXW(IDXW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .o_rsp_idx   (rsp_idx),
    .o_rsp_quo   (rsp_quo),
    .o_rsp_rem   (rsp_rem),
    .o_rsp_dbz   (rsp_dbz),
    .o_arb_busy  (arb_busy),
    .o_div_start (div_start),
    .o_div_a     (div_a),
    .o_div_b     (div_b),
    .i_div_busy  (m_busy | tb_busy),
    .i_div_done  (m_done | tb_done),
    .i_div_valid (m_valid | tb_done),
    .i_div_dbz   (m_dbz),
    .i_div_val   (m_val),
    .i_div_rem   (m_rem)
  );

  // Divider model: done WIDTH+1 cycles after start, or one cycle after for b==0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_dbz <= 1'b0;
      m_val <= 32'd0; m_rem <= 32'd0; m_a <= 32'd0; m_b <= 32'd0; m_cnt <= 0;
    end else begin
      m_done  <= 1'b0;
      m_valid <= 1'b0;
      if (div_start) begin
        m_a <= div_a;
        m_b <= div_b;
        if (div_b == 32'd0) begin
          m_done <= 1'b1;
          m_dbz  <= 1'b1;
          m_val  <= 32'hDEADBEEF;
          m_rem  <= 32'h0BADF00D;
        end else begin
          m_busy <= 1'b1;
          m_dbz  <= 1'b0;
          m_cnt  <= WIDTH - 1;
        end
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_valid <= 1'b1;
          m_val   <= m_a / m_b;
          m_rem   <= m_a % m_b;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push(input int idx, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                      input logic d);
    rsp_t e;
    e.idx = IDXW'(idx);
    e.quo = q;
    e.rem = r;
    e.dbz = d;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    rsp_t e;
    chk({tag, "_sb_has_entry"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh(int'(e.idx))));
      chk({tag, "_rsp_idx"},   64'(rsp_idx),   64'(e.idx));
      chk({tag, "_rsp_quo"},   64'(rsp_quo),   64'(e.quo));
      chk({tag, "_rsp_rem"},   64'(rsp_rem),   64'(e.rem));
      chk({tag, "_rsp_dbz"},   64'(rsp_dbz),   64'(e.dbz));
    end
  endtask

  // Advance cycles until a response strobe (bounded), recording start pulses
  // and any grant seen while the arbiter is occupied.
  task automatic wait_rsp(input logic [NREQ-1:0] clr, input int max, output int n,
                          output int starts, output int first_start, output logic any_ready);
    n = 0; starts = 0; first_start = 0; any_ready = 1'b0;
    do begin
      @(negedge clk);
      req_valid = req_valid & ~clr;
      #1;
      n++;
      if (div_start) begin
        starts++;
        if (first_start == 0) first_start = n;
        st_a = div_a;
        st_b = div_b;
      end
      if (rsp_valid == 4'b0000 && req_ready != 4'b0000) any_ready = 1'b1;
    end while (rsp_valid == 4'b0000 && n < max);
  endtask

  // Serve one already-presented request: grant, latency, start count, response.
  task automatic serve(input string tag, input int idx, input logic [WIDTH-1:0] q,
                       input logic [WIDTH-1:0] r, input logic d, input int lat,
                       input int exp_starts, input logic [NREQ-1:0] clr);
    int n, starts, fs;
    logic any_ready;
    push(idx, q, r, d);
    chk({tag, "_grant"}, 64'(req_ready), 64'(oh(idx)));
    wait_rsp(clr, 100, n, starts, fs, any_ready);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_start_count"}, 64'(starts), 64'(exp_starts));
    chk({tag, "_start_cycle"}, 64'(fs), 64'((exp_starts > 0) ? 1 : 0));
    chk({tag, "_ready_low_busy"}, 64'(any_ready), 64'd0);
    pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, starts, fs, cnt_rsp, cnt_busy;
    logic any_ready, hold_start;
    int rr_idx[5];
    logic [WIDTH-1:0] rr_q[4];
    logic [WIDTH-1:0] rr_r[4];

    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
    tb_busy = 1'b0; tb_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // reset state, with requests asserted
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", {rsp_quo, rsp_rem}, 64'd0);
    chk("rst_rsp_idx_dbz", {rsp_idx, rsp_dbz}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, 64'd0);
    chk("rst_start_busy", {div_start, arb_busy}, 64'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // round robin: all four valid, grants 0,1,2,3,0 with 35-cycle spacing
    @(negedge clk);
    set_op(0, 32'd1000, 32'd10);  rr_q[0] = 32'd100; rr_r[0] = 32'd0;
    set_op(1, 32'd12345, 32'd100); rr_q[1] = 32'd123; rr_r[1] = 32'd45;
    set_op(2, 32'd255, 32'd16);   rr_q[2] = 32'd15;  rr_r[2] = 32'd15;
    set_op(3, 32'd7, 32'd9);      rr_q[3] = 32'd0;   rr_r[3] = 32'd7;
    rr_idx[0] = 0; rr_idx[1] = 1; rr_idx[2] = 2; rr_idx[3] = 3; rr_idx[4] = 0;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      serve("rr", rr_idx[g], rr_q[rr_idx[g]], rr_r[rr_idx[g]], 1'b0, WIDTH + 3, 1,
            (g == 4) ? 4'b1111 : 4'b0000);
    end

    // single request from requester 2: 100 / 7
    @(negedge clk);
    set_op(2, 32'd100, 32'd7);
    req_valid = 4'b0100;
    #1;
    serve("single", 2, 32'd14, 32'd2, 1'b0, 35, 1, 4'b0100);
    chk("single_div_ab", {st_a, st_b}, {32'd100, 32'd7});

    // divide by zero from requester 1
    @(negedge clk);
    set_op(1, 32'd9, 32'd0);
    req_valid = 4'b0010;
    #1;
`ifdef DIV_ARB_DBZ_BYPASS_EN
    serve("dbz", 1, 32'hFFFFFFFF, 32'd9, 1'b1, 1, 0, 4'b0010);
`else
    serve("dbz", 1, 32'd0, 32'd0, 1'b1, 3, 1, 4'b0010);
`endif

    // divider busy holds the arbiter in ISSUE without a start pulse
    @(negedge clk);
    tb_busy = 1'b1;
    set_op(0, 32'd50, 32'd5);
    req_valid = 4'b0001;
    #1;
    push(0, 32'd10, 32'd0, 1'b0);
    chk("hold_grant", 64'(req_ready), 64'(oh(0)));
    hold_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      if (div_start) hold_start = 1'b1;
    end
    chk("hold_no_start", 64'(hold_start), 64'd0);
    chk("hold_arb_busy", 64'(arb_busy), 64'd1);
    @(negedge clk);
    tb_busy = 1'b0;
    #1;
    chk("hold_release_start", 64'(div_start), 64'd1);
    wait_rsp(4'b0000, 100, n, starts, fs, any_ready);
    chk("hold_latency", 64'(n), 64'(WIDTH + 2));
    chk("hold_single_start", 64'(starts), 64'd0);
    pop_chk("hold");

    // reset 10 cycles after div_start aborts the request
    @(negedge clk);
    set_op(3, 32'd1000, 32'd3);
    req_valid = 4'b1000;
    #1;
    chk("abort_grant", 64'(req_ready), 64'(oh(3)));
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("abort_start", 64'(div_start), 64'd1);
    repeat (10) @(negedge clk);
    req_valid = 4'b0010;
    rst = 1'b1;
    #1;
    chk("abort_outputs_zero",
        {req_ready, rsp_valid, rsp_idx, rsp_dbz, div_start, arb_busy}, 64'd0);
    chk("abort_data_zero", {rsp_quo, rsp_rem}, 64'd0);
    chk("abort_div_ab_zero", {div_a, div_b}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    req_valid = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    cnt_rsp = 0; cnt_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 4'b0000) cnt_rsp++;
      if (arb_busy) cnt_busy++;
    end
    chk("abort_no_rsp", 64'(cnt_rsp), 64'd0);
    chk("abort_stay_idle", 64'(cnt_busy), 64'd0);

    // new request after reset completes normally
    @(negedge clk);
    set_op(1, 32'd77, 32'd7);
    req_valid = 4'b0010;
    #1;
    serve("post_rst", 1, 32'd11, 32'd0, 1'b0, 35, 1, 4'b0010);

    // corner operands; requester 0 waits while requester 3 is served
    @(negedge clk);
    set_op(0, 32'hFFFFFFFF, 32'd1);
    set_op(3, 32'd3, 32'd5);
    req_valid = 4'b1001;
    #1;
    serve("corner_3_5", 3, 32'd0, 32'd3, 1'b0, 35, 1, 4'b1000);
    serve("corner_max_1", 0, 32'hFFFFFFFF, 32'd0, 1'b0, 35, 1, 4'b0001);

    @(negedge clk);
    #1;
    chk("final_idle", {req_ready, rsp_valid, arb_busy}, 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
